// File: rtl/dmem_pkg.sv
// Shared definitions for the sized data memory: funct3 codes, FSM encoding,
// byte-enable generation, store lane replication and load extraction.
// Pure combinational helpers, no state.
package dmem_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_DONE = 2'd2
  } dmem_state_t;

  // size: funct3[1:0] (00 byte, 01 half, 10 word); lane: address[1:0]
  function automatic logic [3:0] byte_en(input logic [1:0] size, input logic [1:0] lane);
    case (size)
      2'b00:   byte_en = 4'b0001 << lane;
      2'b01:   byte_en = lane[1] ? 4'b1100 : 4'b0011;
      default: byte_en = 4'b1111;
    endcase
  endfunction

  // Replicate the LSB-aligned store data across all lanes; the byte enables
  // then pick out the lanes that are actually written.
  function automatic logic [31:0] store_lanes(input logic [1:0] size, input logic [31:0] wd);
    case (size)
      2'b00:   store_lanes = {4{wd[7:0]}};
      2'b01:   store_lanes = {2{wd[15:0]}};
      default: store_lanes = wd;
    endcase
  endfunction

  function automatic logic [31:0] load_extend(input logic [31:0] word, input logic [2:0] f3,
                                              input logic [1:0] lane);
    logic [31:0] sh;
    sh = word >> {lane, 3'b000};
    case (f3)
      F3_B:    load_extend = {{24{sh[7]}}, sh[7:0]};
      F3_H:    load_extend = {{16{sh[15]}}, sh[15:0]};
      F3_BU:   load_extend = {24'd0, sh[7:0]};
      F3_HU:   load_extend = {16'd0, sh[15:0]};
      default: load_extend = word;
    endcase
  endfunction

endpackage

// File: rtl/dmem_byte_array.sv
// Word-indexed storage of DEPTH_WORDS x 4 byte lanes, little-endian.
// Latency: write on the rising edge when we=1; read is combinational.
// Backpressure: none, always accepts.
// Ports: clk; we/be/idx/wdata write the indexed word; rdata returns it.
module dmem_byte_array #(
  parameter int DEPTH_WORDS = 256,
  parameter int IDX_W       = $clog2(DEPTH_WORDS)
) (
  input  logic             clk,
  input  logic             we,
  input  logic [3:0]       be,
  input  logic [IDX_W-1:0] idx,
  input  logic [31:0]      wdata,
  output logic [31:0]      rdata
);

  logic [3:0][7:0] mem [DEPTH_WORDS];

  always_ff @(posedge clk) begin
    if (we) begin
      for (int b = 0; b < 4; b++) begin
        if (be[b]) mem[idx][b] <= wdata[8*b +: 8];
      end
    end
  end

  assign rdata = mem[idx];

endmodule

// File: rtl/data_memory_sized.sv
// Byte-addressed 32-bit data memory with sized/signed loads and byte/half/word stores.
// Latency: request sampled at edge N -> ready (and error) pulse in cycle N+1+WAIT_CYCLES.
// Backpressure: one request at a time; requests while busy are ignored.
// Ports: clk, reset (sync, active-high); MemRead/MemWrite/address/write_data/funct3
// request; read_data (held until next good load), ready, error, busy.
module data_memory_sized
  import dmem_pkg::*;
#(
  parameter int          DEPTH_WORDS = 256,
  parameter int          ADDR_W      = 32,
  parameter int unsigned BASE_ADDR   = 0,
  parameter int          WAIT_CYCLES = 0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              MemRead,
  input  logic              MemWrite,
  input  logic [ADDR_W-1:0] address,
  input  logic [31:0]       write_data,
  input  logic [2:0]        funct3,
  output logic [31:0]       read_data,
  output logic              ready,
  output logic              error,
  output logic              busy
);

  localparam int                IDX_W     = $clog2(DEPTH_WORDS);
  localparam logic [ADDR_W-1:0] BASE_A    = ADDR_W'(BASE_ADDR);
  localparam logic [3:0]        WAIT_LOAD = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;
  localparam dmem_state_t       ST_CAP    = (WAIT_CYCLES > 0) ? ST_WAIT : ST_DONE;

  dmem_state_t       state, state_nxt;
  logic [3:0]        wait_cnt;
  logic              req_rd, req_wr;
  logic [ADDR_W-1:0] req_addr;
  logic [31:0]       req_wdata;
  logic [2:0]        req_f3;

  logic              capture, done_cycle, mem_we;
  logic [ADDR_W-1:0] off;
  logic [1:0]        lane, size;
  logic              f3_ok, misal, out_of_range, req_err;
  logic [31:0]       mem_rdata;

  // Offset from the window base; BASE_ADDR is word aligned so off[1:0] is the lane.
  assign off  = req_addr - BASE_A;
  assign lane = off[1:0];
  assign size = req_f3[1:0];

  assign f3_ok = req_wr ? (req_f3 inside {F3_B, F3_H, F3_W})
                        : (req_f3 inside {F3_B, F3_H, F3_W, F3_BU, F3_HU});
  assign misal = ((size == 2'b01) && lane[0]) || ((size == 2'b10) && (lane != 2'b00));
  // Below the base wraps the subtraction, so it is caught separately.
  assign out_of_range = (req_addr < BASE_A) || (|off[ADDR_W-1:IDX_W+2]);
  assign req_err = (req_rd & req_wr) | ~f3_ok | misal | out_of_range;

  // State register plus registered outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= ST_IDLE;
      wait_cnt  <= 4'd0;
      ready     <= 1'b0;
      error     <= 1'b0;
      read_data <= 32'd0;
    end else begin
      state <= state_nxt;
      ready <= done_cycle;
      error <= done_cycle & req_err;
      if (capture) begin
        wait_cnt <= WAIT_LOAD;
      end else if ((state == ST_WAIT) && (wait_cnt != 4'd0)) begin
        wait_cnt <= wait_cnt - 4'd1;
      end
      if (done_cycle && req_rd && !req_err) begin
        read_data <= load_extend(mem_rdata, req_f3, lane);
      end
    end
  end

  // Request capture; no reset needed, only consumed after a capture.
  always_ff @(posedge clk) begin
    if (capture) begin
      req_rd    <= MemRead;
      req_wr    <= MemWrite;
      req_addr  <= address;
      req_wdata <= write_data;
      req_f3    <= funct3;
    end
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (MemRead || MemWrite) state_nxt = ST_CAP;
      ST_WAIT: if (wait_cnt == 4'd0) state_nxt = ST_DONE;
      ST_DONE: state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  // FSM outputs; the write is gated by reset so an aborted store never lands.
  always_comb begin
    capture    = (state == ST_IDLE) && (MemRead || MemWrite);
    done_cycle = (state == ST_DONE);
    busy       = (state != ST_IDLE);
    mem_we     = done_cycle && req_wr && !req_err && !reset;
  end

  dmem_byte_array #(
    .DEPTH_WORDS (DEPTH_WORDS),
    .IDX_W       (IDX_W)
  ) u_array (
    .clk   (clk),
    .we    (mem_we),
    .be    (byte_en(size, lane)),
    .idx   (off[IDX_W+1:2]),
    .wdata (store_lanes(size, req_wdata)),
    .rdata (mem_rdata)
  );

endmodule

// File: doc/data_memory_sized.md
Name: data_memory_sized

Overview:
- Parametrised successor to the single-cycle word data memory.
- Byte-addressed 32-bit data memory with RISC-V style sized, signed and unsigned loads, and byte and halfword stores with internal byte enables.
- Configurable wait states, a done/ready handshake, and error flagging for misaligned, out-of-range or conflicting requests.
- Sits between the datapath MEM stage (or a multicycle controller) and local data storage.

Parameters:
- DEPTH_WORDS, 256: number of 32-bit words stored. Must be a power of two, at least 4.
- ADDR_W, 32: width of the byte address.
- BASE_ADDR, 0: byte address of word 0. Must be 4-byte aligned.
- WAIT_CYCLES, 0: extra cycles inserted before completion. Range 0..15.

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-high reset
- MemRead  in  1  load request, sampled in IDLE
- MemWrite  in  1  store request, sampled in IDLE
- address  in  ADDR_W  byte address
- write_data  in  32  store data, LSB-aligned
- funct3  in  3  size/sign code: 000 lb, 001 lh, 010 lw, 100 lbu, 101 lhu
- read_data  out  32  load result, extended to 32 bits
- ready  out  1  one-cycle completion pulse
- error  out  1  one-cycle error pulse, asserted together with ready
- busy  out  1  high while a request is in flight

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-high.
- Reset values: read_data=0, ready=0, error=0, busy=0, FSM=IDLE. Array contents are not reset.
- FSM states: IDLE, WAIT, DONE.
- IDLE: if MemRead|MemWrite, capture address, write_data, funct3 and the request type. Next state is WAIT if WAIT_CYCLES>0, else DONE. busy=1 from the next cycle.
- WAIT: a down-counter is loaded with WAIT_CYCLES-1. Go to DONE when it reaches 0.
- DONE (one cycle):
  - Perform the access using the captured values.
  - ready=1 registered, so it is visible in the cycle after DONE is entered.
  - Return to IDLE.
- Latency: request sampled at edge N -> ready high during cycle N+1+WAIT_CYCLES. Back-to-back requests are accepted at that same edge.
- Requests while busy: ignored. The master holds off until ready.
- Error conditions, decided at DONE:
  - MemRead and MemWrite both high at capture.
  - funct3 not in the legal set (store legal set: 000, 001, 010).
  - Misaligned: halfword with addr[0]!=0, word with addr[1:0]!=0.
  - Out of range: addr < BASE_ADDR, or (addr-BASE_ADDR)>>2 >= DEPTH_WORDS.
- On error: ready=1, error=1, no array write, read_data unchanged.
- Load:
  - Word index = (addr-BASE_ADDR)>>2, byte lane = addr[1:0].
  - lb/lh sign-extend. lbu/lhu zero-extend.
  - read_data updates only on a successful load and holds until the next successful load.
- Store:
  - sb writes write_data[7:0] to lane addr[1:0].
  - sh writes write_data[15:0] to lanes {addr[1],0} and {addr[1],1}.
  - sw writes all 4 lanes.
  - Untouched lanes keep their value (per-byte write enables, little-endian).
- Reset mid-operation: the request is aborted, no write occurs, and no ready pulse is issued.
- Read-after-write: a load completing after a store to the same word returns the new data. No forwarding is needed because accesses are serialised.

Decomposition:
- Shared package dmem_pkg:
  - funct3 localparams F3_B, F3_H, F3_W, F3_BU, F3_HU.
  - FSM state encoding.
  - Function for the byte-enable mask from size and lane.
  - Function for load extraction and extension.
- One natural sub-module, dmem_byte_array: DEPTH_WORDS x 4 byte lanes, synchronous write with 4-bit byte enable, combinational read of the indexed word.

Test Plan:
- sw 0x11223344 @0x8, then lw @0x8 with WAIT_CYCLES=0 -> ready one cycle after each request is sampled, read_data=0x11223344, error=0.
- sb 0xAB @0x9, then lw @0x8 -> 0x1122AB44. lb @0x9 -> 0xFFFFFFAB. lbu @0x9 -> 0x000000AB.
- sh 0x8001 @0xA, then lh @0xA -> 0xFFFF8001. lhu @0xA -> 0x00008001.
- Misaligned lw @0x6, sh @0x3, and lw @(DEPTH_WORDS*4) -> ready=1, error=1, memory unchanged, read_data held.
- WAIT_CYCLES=3: lw -> ready exactly 4 cycles after sampling. A second request asserted while busy is ignored. MemRead and MemWrite both high -> error.
- Assert reset during WAIT of a sw 0xDEADBEEF @0x10 -> busy=0, no ready pulse. A later lw @0x10 returns the prior value.
